sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 136 +++++++++++++
 tb/tb_sdram_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port round-robin arbiter in front of a single-command SDRAM controller
module sdram_arbiter #(
    parameter int AW    = 23,
    parameter int DW    = 32,
    parameter int WR_TO = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req0_rw,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic [DW-1:0] req0_rdata,
    output logic          req0_rvalid,
    input  logic          req1_valid,
    input  logic          req1_rw,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic [DW-1:0] req1_rdata,
    output logic          req1_rvalid,
    output logic [AW-1:0] ctl_addr,
    output logic          ctl_rw,
    output logic [DW-1:0] ctl_wdata,
    output logic          ctl_in_valid,
    input  logic          ctl_busy,
    input  logic [DW-1:0] ctl_rdata,
    input  logic          ctl_out_valid,
    output logic          owner,
    output logic          active
);
    localparam int CW = $clog2(WR_TO + 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_TO - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] wr_cnt;
    logic          cooldown;
    logic          pick;
    logic          done;

    // Contention goes to the port that did not win last time.
    always_comb begin
        pick = (req0_valid && req1_valid) ? ~owner : req1_valid;
    end

    // A write counts as finished either when busy falls or when busy never showed up in time.
    always_comb begin
        done = 1'b0;
        case (state)
            WAIT_BUSY: done = ctl_rw ? (!ctl_busy && (wr_cnt >= WR_LAST)) : ctl_out_valid;
            WAIT_DONE: done = ctl_rw ? !ctl_busy : ctl_out_valid;
            default:   done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            cooldown     <= 1'b0;
            owner        <= 1'b1;
            active       <= 1'b0;
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            req0_rvalid  <= 1'b0;
            req1_rvalid  <= 1'b0;
            req0_rdata   <= '0;
            req1_rdata   <= '0;
            ctl_addr     <= '0;
            ctl_rw       <= 1'b0;
            ctl_wdata    <= '0;
            ctl_in_valid <= 1'b0;
        end else begin
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            req0_rvalid  <= 1'b0;
            req1_rvalid  <= 1'b0;
            ctl_in_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // One idle cycle after completion keeps accepts at least four cycles apart.
                    if (cooldown) begin
                        cooldown <= 1'b0;
                    end else if ((req0_valid || req1_valid) && !ctl_busy) begin
                        owner        <= pick;
                        active       <= 1'b1;
                        ctl_addr     <= pick ? req1_addr  : req0_addr;
                        ctl_rw       <= pick ? req1_rw    : req0_rw;
                        ctl_wdata    <= pick ? req1_wdata : req0_wdata;
                        req0_ready   <= ~pick;
                        req1_ready   <= pick;
                        ctl_in_valid <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_cnt <= CW'(1);
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (done) begin
                        state    <= IDLE;
                        active   <= 1'b0;
                        cooldown <= 1'b1;
                        wr_cnt   <= '0;
                        if (!ctl_rw) begin
                            if (owner) begin
                                req1_rdata  <= ctl_rdata;
                                req1_rvalid <= 1'b1;
                            end else begin
                                req0_rdata  <= ctl_rdata;
                                req0_rvalid <= 1'b1;
                            end
                        end
                    end else if (state == WAIT_BUSY) begin
                        if (ctl_busy) begin
                            state <= WAIT_DONE;
                        end else if (wr_cnt < WR_LAST) begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int WR_TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req0_rw = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_ready, req0_rvalid;
    logic [DW-1:0] req0_rdata;
    logic          req1_valid = 1'b0, req1_rw = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_ready, req1_rvalid;
    logic [DW-1:0] req1_rdata;
    logic [AW-1:0] ctl_addr;
    logic          ctl_rw, ctl_in_valid;
    logic [DW-1:0] ctl_wdata;
    logic          ctl_busy = 1'b0;
    logic [DW-1:0] ctl_rdata = '0;
    logic          ctl_out_valid = 1'b0;
    logic          owner, active;

    sdram_arbiter #(.AW(AW), .DW(DW), .WR_TO(WR_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rdata(req1_rdata), .req1_rvalid(req1_rvalid),
        .ctl_addr(ctl_addr), .ctl_rw(ctl_rw), .ctl_wdata(ctl_wdata), .ctl_in_valid(ctl_in_valid),
        .ctl_busy(ctl_busy), .ctl_rdata(ctl_rdata), .ctl_out_valid(ctl_out_valid),
        .owner(owner), .active(active)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            v0, rw0, v1, rw1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] w0, w1;
        int            d, l;
        logic [DW-1:0] rd;
        int            ep, elat;
    } vec_t;

    int            checks = 0;
    int            failures = 0;
    int            strobes = 0;
    int            last_wait = 0;
    bit            m_owner = 1'b1;
    logic [DW-1:0] m_rdata [2];
    vec_t          tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (ctl_in_valid) strobes++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        ctl_busy = 1'b0; ctl_out_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        m_owner = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " flags"}, {req0_ready, req1_ready, req0_rvalid, req1_rvalid, ctl_in_valid, active, ctl_rw}, 0);
        chk({nm, " data"}, {ctl_addr, ctl_wdata}, 0);
        chk({nm, " rdata"}, {req0_rdata, req1_rdata}, 0);
        chk({nm, " owner"}, owner, 1);
    endtask

    // Requests are driven by the caller; this plays the controller and checks one transaction.
    task automatic txn(input string nm, input int d, input int l, input logic [DW-1:0] rd,
                       input int ep, input int elat, input bit drop);
        logic erw;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        int s0, t;
        bit got;
        erw = ep[0] ? req1_rw : req0_rw;
        ea  = ep[0] ? req1_addr : req0_addr;
        ew  = ep[0] ? req1_wdata : req0_wdata;
        s0 = strobes;
        got = 1'b0;
        last_wait = 0;
        while (!got && last_wait < 40) begin
            tick();
            last_wait++;
            got = req0_ready | req1_ready;
        end
        chk({nm, " accept"}, got, 1);
        if (!got) return;
        chk({nm, " ready"}, {req1_ready, req0_ready}, ep[0] ? 2'b10 : 2'b01);
        chk({nm, " strobe"}, ctl_in_valid, 1);
        chk({nm, " owner"}, owner, ep[0]);
        chk({nm, " active"}, active, 1);
        chk({nm, " cmd"}, {ctl_rw, ctl_addr}, {erw, ea});
        if (erw) chk({nm, " wdata"}, ctl_wdata, ew);
        m_owner = ep[0];
        if (ep[0]) begin
            req1_addr = AW'($urandom); req1_wdata = $urandom;
            if (drop) req1_valid = 1'b0;
        end else begin
            req0_addr = AW'($urandom); req0_wdata = $urandom;
            if (drop) req0_valid = 1'b0;
        end
        t = 0;
        while (t < 40) begin
            ctl_busy = (l > 0) && (t >= d) && (t < d + l);
            if (erw) begin
                ctl_out_valid = 1'($urandom_range(0, 1));
                ctl_rdata = $urandom;
            end else begin
                ctl_out_valid = (t == d + l);
                ctl_rdata = (t == d + l) ? rd : $urandom;
            end
            tick();
            t++;
            if (!active) break;
        end
        ctl_busy = 1'b0;
        ctl_out_valid = 1'b0;
        chk({nm, " latency"}, t, elat);
        if (!erw) begin
            chk({nm, " rvalid"}, {req1_rvalid, req0_rvalid}, ep[0] ? 2'b10 : 2'b01);
            chk({nm, " rdata"}, ep[0] ? req1_rdata : req0_rdata, rd);
            chk({nm, " other rdata"}, ep[0] ? req0_rdata : req1_rdata, m_rdata[1 - ep]);
            m_rdata[ep] = rd;
        end else begin
            chk({nm, " no rvalid"}, {req1_rvalid, req0_rvalid}, 0);
        end
        chk({nm, " cmd stable"}, ctl_addr, ea);
        chk({nm, " one strobe"}, strobes - s0, 1);
        tick();
        chk({nm, " quiet"}, {req1_rvalid, req0_rvalid, req1_ready, req0_ready, ctl_in_valid}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit v0, v1, erw;
        int ep, d, l, elat;
        logic [DW-1:0] rd;

        tbl[0] = '{1, 0, 0, 0, 23'h000010, 23'h0,      32'h0,        32'h0,        2, 1, 32'hDEADBEEF, 0, 4};
        tbl[1] = '{0, 0, 1, 1, 23'h0,      23'h00ABCD, 32'h0,        32'h12345678, 1, 3, 32'h0,        1, 5};
        tbl[2] = '{1, 1, 0, 0, 23'h000777, 23'h0,      32'hCAFEF00D, 32'h0,        1, 0, 32'h0,        0, 8};
        tbl[3] = '{1, 0, 1, 0, 23'h000100, 23'h000200, 32'h0,        32'h0,        1, 0, 32'h11112222, 1, 2};
        tbl[4] = '{1, 0, 1, 0, 23'h000101, 23'h000201, 32'h0,        32'h0,        3, 2, 32'h33334444, 0, 6};
        tbl[5] = '{1, 1, 1, 1, 23'h000102, 23'h000202, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 2, 32'h0,        1, 5};
        tbl[6] = '{0, 0, 1, 0, 23'h0,      23'h7FFFFF, 32'h0,        32'h0,        1, 2, 32'h55556666, 1, 4};
        tbl[7] = '{1, 0, 0, 0, 23'h7FFFFF, 23'h0,      32'h0,        32'h0,        4, 0, 32'h77778888, 0, 5};

        do_reset();
        chk_reset("reset");

        for (int i = 0; i < 8; i++) begin
            req0_valid = tbl[i].v0; req0_rw = tbl[i].rw0; req0_addr = tbl[i].a0; req0_wdata = tbl[i].w0;
            req1_valid = tbl[i].v1; req1_rw = tbl[i].rw1; req1_addr = tbl[i].a1; req1_wdata = tbl[i].w1;
            txn($sformatf("vec%0d", i), tbl[i].d, tbl[i].l, tbl[i].rd, tbl[i].ep, tbl[i].elat, 1'b1);
            chk($sformatf("vec%0d wait", i), last_wait, 1);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end

        // Busy controller holds off the accept until busy falls.
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 23'h000040;
        ctl_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("busyhold%0d", i), {req1_ready, req0_ready, ctl_in_valid}, 0);
        end
        ctl_busy = 1'b0;
        txn("busyreq", 1, 1, 32'h0BADF00D, 0, 3, 1'b1);
        chk("busyreq wait", last_wait, 1);

        // Continuous contention from reset alternates 0,1,0,1.
        do_reset();
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 23'h000123;
        req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 23'h000456;
        for (int k = 0; k < 4; k++) begin
            txn($sformatf("cont%0d", k), 1, 0, $urandom, k % 2, 2, 1'b0);
            if (k > 0) chk($sformatf("cont%0d spacing", k), last_wait, 1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();

        // Reset asserted while a read sits in WAIT_DONE.
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 23'h000999;
        last_wait = 0;
        while (!req0_ready && last_wait < 40) begin tick(); last_wait++; end
        chk("rstmid accept", req0_ready, 1);
        req0_valid = 1'b0;
        ctl_busy = 1'b1;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1 chk_reset("rstmid");
        tick();
        rst_n = 1'b1;
        m_owner = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0;
        ctl_busy = 1'b0; ctl_out_valid = 1'b1; ctl_rdata = 32'hFEEDFACE;
        tick();
        ctl_out_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rstmid after%0d", i), {req0_rvalid, req1_rvalid, ctl_in_valid, active}, 0);
        end

        // Randomised traffic against the arbitration and timing rules.
        for (int n = 0; n < 30; n++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            req0_valid = v0; req0_rw = 1'($urandom_range(0, 1));
            req0_addr = AW'($urandom); req0_wdata = $urandom;
            req1_valid = v1; req1_rw = 1'($urandom_range(0, 1));
            req1_addr = AW'($urandom); req1_wdata = $urandom;
            d = $urandom_range(1, 5);
            l = $urandom_range(0, 4);
            rd = $urandom;
            ep = (v0 && v1) ? (m_owner ? 0 : 1) : (v0 ? 0 : 1);
            erw = (ep == 1) ? req1_rw : req0_rw;
            elat = (erw && l == 0) ? WR_TO : d + l + 1;
            txn($sformatf("rnd%0d", n), d, l, rd, ep, elat, 1'b1);
            chk($sformatf("rnd%0d wait", n), last_wait, 1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
